// File: rtl/fb_pkg.sv
// Shared types and geometry for the result-framebuffer arbiter.
package fb_pkg;
   localparam int H_ACTIVE      = 640;
   localparam int V_ACTIVE      = 480;
   localparam int FB_WORDS      = H_ACTIVE * V_ACTIVE;
   localparam int ADDR_W        = 19;
   localparam int DATA_W        = 24;
   localparam int WR_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {IDLE, SCAN, BLANK} arb_state_t;
endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Writer-side handshake into the framebuffer arbiter.
interface frame_mem_arbiter_if;
   import fb_pkg::*;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous write queue holding deferred pixel writes until blanking.
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = WR_FIFO_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wr_entry_t push_entry,
   input  logic      pop,
   output wr_entry_t head,
   output logic      full,
   output logic      empty
);
   localparam int PTR_W = $clog2(DEPTH);

   wr_entry_t        store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload needs no reset: it is only observed through the count.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_entry;
   end

   assign head  = store[rd_ptr];
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares the single-port result framebuffer between VGA scan-out and the deferred writer.
//  state | meaning
//  IDLE  | after reset, no active pixel seen yet; drains writes
//  SCAN  | active video, scan-out owns the memory
//  BLANK | blanking, queued writes drain one per cycle
module frame_mem_arbiter
   import fb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           h_count,
   input  logic [9:0]           v_count,
   frame_mem_arbiter_if.slave   wr,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [7:0]           R,
   output logic [7:0]           G,
   output logic [7:0]           B,
   output logic                 pix_valid,
   output logic                 frame_done,
   output logic                 wr_oob
);
   arb_state_t        state;
   logic              active;
   logic              last_pix;
   logic [ADDR_W-1:0] v_ext;
   logic [ADDR_W-1:0] h_ext;
   logic [ADDR_W-1:0] scan_addr;
   logic              accept;
   logic              in_range;
   logic              fifo_full;
   logic              fifo_empty;
   wr_entry_t         fifo_head;
   wr_entry_t         push_entry;
   pixel_t            px;

   assign active   = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
   assign last_pix = active && (v_count == 10'(V_ACTIVE-1)) && (h_count == 10'(H_ACTIVE-1));

   // v*640 + h as shifts, widened first so nothing is lost.
   assign v_ext     = ADDR_W'(v_count);
   assign h_ext     = ADDR_W'(h_count);
   assign scan_addr = (v_ext << 9) + (v_ext << 7) + h_ext;

   assign wr.wr_ready = !fifo_full;
   assign accept      = wr.wr_valid && wr.wr_ready;
   assign in_range    = (wr.wr_addr < ADDR_W'(FB_WORDS));
   assign push_entry  = '{addr: wr.wr_addr, data: wr.wr_data};

   fb_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept && in_range),
      .push_entry (push_entry),
      .pop        (mem_we),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Bus decision is made on the current counts so a write can never land in an active cycle.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (rst_n) begin
         if (active) begin
            mem_addr = scan_addr;
         end else if (!fifo_empty) begin
            mem_we    = 1'b1;
            mem_addr  = fifo_head.addr;
            mem_wdata = fifo_head.data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         wr_oob     <= 1'b0;
      end else begin
         case (state)
            IDLE:    state <= active ? SCAN : IDLE;
            SCAN:    state <= active ? SCAN : BLANK;
            BLANK:   state <= active ? SCAN : BLANK;
            default: state <= IDLE;
         endcase
         pix_valid  <= active;
         frame_done <= last_pix;
         if (accept && !in_range) wr_oob <= 1'b1;
      end
   end

   assign px = mem_rdata;
   assign R  = pix_valid ? px.r : 8'h00;
   assign G  = pix_valid ? px.g : 8'h00;
   assign B  = pix_valid ? px.b : 8'h00;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed vector bench for frame_mem_arbiter with a 1-cycle-latency memory model.
module tb_frame_mem_arbiter;
   import fb_pkg::*;

   logic              clk;
   logic              rst_n;
   logic [9:0]        h_count;
   logic [9:0]        v_count;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [7:0]        R, G, B;
   logic              pix_valid;
   logic              frame_done;
   logic              wr_oob;
   logic [ADDR_W-1:0] addr_q;

   int errors = 0;
   int checks = 0;

   frame_mem_arbiter_if wr_if ();

   frame_mem_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .h_count    (h_count),
      .v_count    (v_count),
      .wr         (wr_if),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .R          (R),
      .G          (G),
      .B          (B),
      .pix_valid  (pix_valid),
      .frame_done (frame_done),
      .wr_oob     (wr_oob)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [23:0] pat(input logic [18:0] a);
      return {a[7:0], a[15:8] ^ 8'hA5, {5'b0, a[18:16]} ^ 8'h3C};
   endfunction

   // Synchronous-read memory: data for the address seen this cycle appears next cycle.
   always @(negedge clk) addr_q = mem_addr;
   always @(posedge clk) mem_rdata <= pat(addr_q);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int v, input int h, input bit wv, input int wa, input int wd);
      v_count        = 10'(v);
      h_count        = 10'(h);
      wr_if.wr_valid = wv;
      wr_if.wr_addr  = 19'(wa);
      wr_if.wr_data  = 24'(wd);
   endtask

   typedef struct {
      int v; int h; bit wv; int wa; int wd;
      int e_addr; bit e_we; int e_wdata; bit e_ready;
      bit e_pv; int rd_addr; bit e_fd;
   } vec_t;

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{600, 0,   0, 0,   0,         0,      0, 0,         1, 0, 0,      0};
      vecs[1]  = '{1,   2,   0, 0,   0,         642,    0, 0,         1, 0, 0,      0};
      vecs[2]  = '{1,   3,   0, 0,   0,         643,    0, 0,         1, 1, 642,    0};
      vecs[3]  = '{1,   640, 0, 0,   0,         0,      0, 0,         1, 1, 643,    0};
      vecs[4]  = '{479, 639, 0, 0,   0,         307199, 0, 0,         1, 0, 0,      0};
      vecs[5]  = '{479, 640, 0, 0,   0,         0,      0, 0,         1, 1, 307199, 1};
      vecs[6]  = '{479, 641, 0, 0,   0,         0,      0, 0,         1, 0, 0,      0};
      vecs[7]  = '{0,   0,   0, 0,   0,         0,      0, 0,         1, 0, 0,      0};
      vecs[8]  = '{2,   639, 0, 0,   0,         1919,   0, 0,         1, 1, 0,      0};
      vecs[9]  = '{480, 0,   0, 0,   0,         0,      0, 0,         1, 1, 1919,   0};
      vecs[10] = '{0,   640, 0, 0,   0,         0,      0, 0,         1, 0, 0,      0};
      vecs[11] = '{5,   10,  1, 100, 'hFF0000,  3210,   0, 0,         1, 0, 0,      0};
      vecs[12] = '{5,   11,  0, 0,   0,         3211,   0, 0,         1, 1, 3210,   0};
      vecs[13] = '{5,   640, 0, 0,   0,         100,    1, 'hFF0000,  1, 1, 3211,   0};
      vecs[14] = '{5,   641, 0, 0,   0,         0,      0, 0,         1, 0, 0,      0};

      // Reset held with counts mid-frame and a writer request pending
      rst_n = 1'b0;
      drive(100, 100, 1, 5, 1);
      repeat (2) @(posedge clk);
      #2;
      chk("rst_mem_addr",   32'(mem_addr),   0);
      chk("rst_mem_we",     32'(mem_we),     0);
      chk("rst_mem_wdata",  32'(mem_wdata),  0);
      chk("rst_rgb",        32'({R, G, B}),  0);
      chk("rst_pix_valid",  32'(pix_valid),  0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_wr_oob",     32'(wr_oob),     0);
      chk("rst_wr_ready",   32'(wr_if.wr_ready), 1);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].v, vecs[i].h, vecs[i].wv, vecs[i].wa, vecs[i].wd);
         #2;
         chk($sformatf("v%0d_mem_addr", i),   32'(mem_addr),        vecs[i].e_addr);
         chk($sformatf("v%0d_mem_we", i),     32'(mem_we),          32'(vecs[i].e_we));
         chk($sformatf("v%0d_mem_wdata", i),  32'(mem_wdata),       vecs[i].e_wdata);
         chk($sformatf("v%0d_wr_ready", i),   32'(wr_if.wr_ready),  32'(vecs[i].e_ready));
         chk($sformatf("v%0d_pix_valid", i),  32'(pix_valid),       32'(vecs[i].e_pv));
         chk($sformatf("v%0d_rgb", i),        32'({R, G, B}),
             vecs[i].e_pv ? 32'(pat(19'(vecs[i].rd_addr))) : 32'd0);
         chk($sformatf("v%0d_frame_done", i), 32'(frame_done),      32'(vecs[i].e_fd));
         tick();
      end

      // Backpressure: fill during active video, then drain in blanking with a push-while-pop
      for (int i = 0; i < 4; i++) begin
         drive(10, i, 1, 1000 + i, i + 1);
         #2;
         chk("bp_ready_push", 32'(wr_if.wr_ready), 1);
         chk("bp_no_we_active", 32'(mem_we), 0);
         tick();
      end
      drive(10, 4, 0, 0, 0);
      #2;
      chk("bp_ready_full", 32'(wr_if.wr_ready), 0);
      chk("bp_we_full_active", 32'(mem_we), 0);
      tick();
      drive(10, 640, 0, 0, 0);
      #2;
      chk("bp_pop0_we", 32'(mem_we), 1);
      chk("bp_pop0_addr", 32'(mem_addr), 1000);
      chk("bp_pop0_ready", 32'(wr_if.wr_ready), 0);
      tick();
      drive(10, 641, 0, 0, 0);
      #2;
      chk("bp_pop1_ready", 32'(wr_if.wr_ready), 1);
      chk("bp_pop1_addr", 32'(mem_addr), 1001);
      chk("bp_pop1_wdata", 32'(mem_wdata), 2);
      tick();
      drive(10, 642, 1, 2000, 'hABCDEF);
      #2;
      chk("bp_pushpop_addr", 32'(mem_addr), 1002);
      chk("bp_pushpop_ready", 32'(wr_if.wr_ready), 1);
      tick();
      drive(10, 643, 0, 0, 0);
      #2;
      chk("bp_pop3_addr", 32'(mem_addr), 1003);
      tick();
      drive(10, 644, 0, 0, 0);
      #2;
      chk("bp_pop4_we", 32'(mem_we), 1);
      chk("bp_pop4_addr", 32'(mem_addr), 2000);
      chk("bp_pop4_wdata", 32'(mem_wdata), 'hABCDEF);
      tick();
      drive(10, 645, 0, 0, 0);
      #2;
      chk("bp_drained_we", 32'(mem_we), 0);
      chk("bp_drained_addr", 32'(mem_addr), 0);
      tick();

      // Out-of-range write is dropped and latches the sticky flag; last valid address still accepted
      drive(600, 0, 1, 307200, 1);
      #2;
      chk("oob_before", 32'(wr_oob), 0);
      chk("oob_ready", 32'(wr_if.wr_ready), 1);
      tick();
      drive(600, 1, 1, 307199, 'h123456);
      #2;
      chk("oob_dropped_we", 32'(mem_we), 0);
      chk("oob_set", 32'(wr_oob), 1);
      tick();
      drive(600, 2, 0, 0, 0);
      #2;
      chk("oob_edge_we", 32'(mem_we), 1);
      chk("oob_edge_addr", 32'(mem_addr), 307199);
      chk("oob_edge_wdata", 32'(mem_wdata), 'h123456);
      chk("oob_sticky", 32'(wr_oob), 1);
      tick();
      drive(600, 3, 0, 0, 0);
      #2;
      chk("oob_after_we", 32'(mem_we), 0);
      chk("oob_sticky2", 32'(wr_oob), 1);
      tick();

      // Reset with three queued writes: they must never reach the memory
      for (int i = 0; i < 3; i++) begin
         drive(20, i, 1, 50 + i, 'h0F0F0F);
         tick();
      end
      drive(20, 3, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #2;
      chk("flush_rst_oob", 32'(wr_oob), 0);
      chk("flush_rst_we", 32'(mem_we), 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(600, i, 0, 0, 0);
         #2;
         chk($sformatf("flush_we%0d", i), 32'(mem_we), 0);
         chk($sformatf("flush_ready%0d", i), 32'(wr_if.wr_ready), 1);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
